// File: rtl/mem_bus_arbiter_if.sv
// Bundle of CPU data port, DMA port and shared bus for the arbiter.
// slave = arbiter side, master = requesters plus bus model.
interface mem_bus_arbiter_if;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        dma_grant;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport slave (
    input  cpu_read, cpu_write,
    input  cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we,
    input  dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output dma_grant,
    output bus_read, bus_write,
    output bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport master (
    output cpu_read, cpu_write,
    output cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we,
    output dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  dma_grant,
    input  bus_read, bus_write,
    input  bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA data-bus arbiter, fixed-length accesses, CPU priority.
// Optional DMA starvation guard: define ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input logic             clk,
  input logic             reset,
  mem_bus_arbiter_if.slave bif
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_acc
    $error("ACCESS_CYCLES out of range 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_lim
    $error("STARVE_LIMIT out of range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;

  logic w_cpu_req;
  logic w_trip;
  logic w_idle;
  logic w_cpu_acc;
  logic w_dma_acc;
  logic w_last;
  logic w_go_cpu;
  logic w_go_dma;

  assign w_cpu_req = bif.cpu_read | bif.cpu_write;
  assign w_idle    = (r_state == IDLE);
  assign w_cpu_acc = (r_state == CPU_ACC);
  assign w_dma_acc = (r_state == DMA_ACC);
  assign w_last    = (r_cnt == 4'd0);

  // A tripped guard lets the DMA jump ahead of a pending CPU request.
  assign w_go_dma = w_idle & bif.dma_req
                  & (w_trip | ~w_cpu_req);
  assign w_go_cpu = w_idle & w_cpu_req
                  & ~(bif.dma_req & w_trip);

  // Arbitration FSM: grant in IDLE, count down, always idle one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_go_dma) begin
            r_state <= DMA_ACC;
            r_cnt   <= CNT_INIT;
          end else if (w_go_cpu) begin
            r_state <= CPU_ACC;
            r_cnt   <= CNT_INIT;
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (w_last) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;

  // Count CPU wins while the DMA waits; any DMA grant or idle DMA clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= 4'd0;
    end else if (!bif.dma_req || w_go_dma) begin
      r_starve <= 4'd0;
    end else if (w_go_cpu && r_starve != 4'hF) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  assign w_trip = (r_starve >= LIMIT);
`else
  assign w_trip = 1'b0;
`endif

  assign bif.cpu_stall = w_cpu_req & ~(w_cpu_acc & w_last);
  assign bif.dma_ack   = w_dma_acc & w_last;
  assign bif.dma_grant = w_dma_acc;
  assign bif.cpu_rdata = (w_cpu_acc & w_last) ? bif.bus_rdata : 32'd0;
  assign bif.dma_rdata = (w_dma_acc & w_last) ? bif.bus_rdata : 32'd0;

  // Bus mux: owner's strobe, address and data; quiet bus in IDLE.
  always_comb begin
    bif.bus_read  = 1'b0;
    bif.bus_write = 1'b0;
    bif.bus_addr  = 32'd0;
    bif.bus_wdata = 32'd0;
    unique case (1'b1)
      w_cpu_acc: begin
        bif.bus_read  = bif.cpu_read & ~bif.cpu_write;
        bif.bus_write = bif.cpu_write;
        bif.bus_addr  = bif.cpu_addr;
        bif.bus_wdata = bif.cpu_wdata;
      end
      w_dma_acc: begin
        bif.bus_read  = ~bif.dma_we;
        bif.bus_write = bif.dma_we;
        bif.bus_addr  = bif.dma_addr;
        bif.bus_wdata = bif.dma_wdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed timing cases, then random
// CPU/DMA traffic against a word-memory model and scoreboard.
module tb_mem_bus_arbiter;

  localparam int AC  = 2;
  localparam int SL  = 4;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bif();

  mem_bus_arbiter #(
    .ACCESS_CYCLES(AC),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bif  (bif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Bus slave: 16-word memory, optional fixed read data.
  logic [31:0] mem [16];
  bit          use_fixed = 1'b1;
  bit          mem_init  = 1'b0;
  logic [31:0] fixed_val = 32'd0;

  assign bif.bus_rdata = use_fixed ? fixed_val : mem[bif.bus_addr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0101;
    end else if (bif.bus_write) begin
      mem[bif.bus_addr[5:2]] <= bif.bus_wdata;
    end
  end

  // Scoreboard.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  logic [31:0] ref_mem [16];
  bit          sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on) begin
      exp_t e;
      chk("strobe_excl", 32'(bif.bus_read & bif.bus_write), 32'd0);
      if ((bif.cpu_read | bif.cpu_write) && !bif.cpu_stall) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_unexpected", 32'd1, 32'd0);
        end else begin
          e = cpu_q.pop_front();
          chk("cpu_bus_write", 32'(bif.bus_write), 32'(e.we));
          chk("cpu_bus_read", 32'(bif.bus_read), 32'(!e.we));
          chk("cpu_bus_addr", bif.bus_addr, e.addr);
          if (e.we) chk("cpu_bus_wdata", bif.bus_wdata, e.wdata);
          else      chk("cpu_rdata", bif.cpu_rdata, e.rdata);
        end
      end
      if (bif.dma_ack) begin
        if (dma_q.size() == 0) begin
          chk("dma_unexpected", 32'd1, 32'd0);
        end else begin
          e = dma_q.pop_front();
          chk("dma_grant_at_ack", 32'(bif.dma_grant), 32'd1);
          chk("dma_bus_write", 32'(bif.bus_write), 32'(e.we));
          chk("dma_bus_addr", bif.bus_addr, e.addr);
          if (e.we) chk("dma_bus_wdata", bif.bus_wdata, e.wdata);
          else      chk("dma_rdata", bif.dma_rdata, e.rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(bit rd, bit wr, int idx, logic [31:0] d);
    exp_t e;
    bit   done = 1'b0;
    bif.cpu_read  = rd;
    bif.cpu_write = wr;
    bif.cpu_addr  = 32'h4000_0000 | (32'(idx) << 2);
    bif.cpu_wdata = d;
    e.we    = wr;
    e.addr  = bif.cpu_addr;
    e.wdata = d;
    e.rdata = ref_mem[idx];
    if (wr) ref_mem[idx] = d;
    cpu_q.push_back(e);
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (!bif.cpu_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("cpu_done");
    step();
    bif.cpu_read  = 1'b0;
    bif.cpu_write = 1'b0;
  endtask

  task automatic dma_op(bit we, int idx, logic [31:0] d);
    exp_t e;
    bit   done = 1'b0;
    bif.dma_req   = 1'b1;
    bif.dma_we    = we;
    bif.dma_addr  = 32'h4000_0000 | (32'(idx) << 2);
    bif.dma_wdata = d;
    e.we    = we;
    e.addr  = bif.dma_addr;
    e.wdata = d;
    e.rdata = ref_mem[idx];
    if (we) ref_mem[idx] = d;
    dma_q.push_back(e);
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (bif.dma_ack) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("dma_done");
    step();
    bif.dma_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   seq[$];
    bit   prev_busy;
    bit   busy;
    bit   seen;
    int   acks;
    bit   exp_d;

    reset         = 1'b0;
    bif.cpu_read  = 1'b0;
    bif.cpu_write = 1'b0;
    bif.cpu_addr  = 32'd0;
    bif.cpu_wdata = 32'd0;
    bif.dma_req   = 1'b0;
    bif.dma_we    = 1'b0;
    bif.dma_addr  = 32'd0;
    bif.dma_wdata = 32'd0;

    // Reset state.
    #1;
    chk("rst_stall", 32'(bif.cpu_stall), 32'd0);
    chk("rst_bus_read", 32'(bif.bus_read), 32'd0);
    chk("rst_bus_write", 32'(bif.bus_write), 32'd0);
    chk("rst_bus_addr", bif.bus_addr, 32'd0);
    chk("rst_dma_ack", 32'(bif.dma_ack), 32'd0);
    chk("rst_dma_grant", 32'(bif.dma_grant), 32'd0);
    chk("rst_cpu_rdata", bif.cpu_rdata, 32'd0);
    bif.cpu_read = 1'b1;
    #1;
    chk("rst_stall_req", 32'(bif.cpu_stall), 32'd1);
    bif.cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();

    // CPU load latency.
    bif.cpu_read = 1'b1;
    bif.cpu_addr = 32'h4000_0010;
    fixed_val    = 32'h0000_1234;
    for (int c = 1; c <= AC + 1; c++) begin
      @(negedge clk);
      chk($sformatf("ld_stall_c%0d", c), 32'(bif.cpu_stall), 32'(c <= AC));
      chk($sformatf("ld_read_c%0d", c), 32'(bif.bus_read), 32'(c >= 2));
      chk($sformatf("ld_rdata_c%0d", c), bif.cpu_rdata,
          (c == AC + 1) ? 32'h0000_1234 : 32'd0);
      if (c == 2) chk("ld_addr", bif.bus_addr, 32'h4000_0010);
    end
    step();
    bif.cpu_read = 1'b0;
    @(negedge clk);
    chk("ld_idle_read", 32'(bif.bus_read), 32'd0);
    step();

    // Simultaneous CPU write and DMA read: CPU first, one idle gap.
    bif.cpu_write = 1'b1;
    bif.cpu_wdata = 32'h5555_AAAA;
    bif.dma_req   = 1'b1;
    bif.dma_we    = 1'b0;
    bif.dma_addr  = 32'h4000_0020;
    fixed_val     = 32'hCAFE_0001;
    acks          = 0;
    for (int c = 1; c <= 2 * AC + 3; c++) begin
      @(negedge clk);
      chk($sformatf("sim_grant_c%0d", c), 32'(bif.dma_grant),
          32'(c >= AC + 3 && c <= 2 * AC + 2));
      chk($sformatf("sim_ack_c%0d", c), 32'(bif.dma_ack),
          32'(c == 2 * AC + 2));
      chk($sformatf("sim_write_c%0d", c), 32'(bif.bus_write),
          32'(c >= 2 && c <= AC + 1));
      if (bif.dma_ack) begin
        acks++;
        chk("sim_dma_rdata", bif.dma_rdata, 32'hCAFE_0001);
      end
      step();
      if (c == AC + 1) bif.cpu_write = 1'b0;
      if (c == 2 * AC + 2) bif.dma_req = 1'b0;
    end
    chk("sim_ack_count", 32'(acks), 32'd1);

    // Read and write together behave as a write.
    bif.cpu_read  = 1'b1;
    bif.cpu_write = 1'b1;
    for (int c = 1; c <= AC + 1; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk($sformatf("both_write_c%0d", c), 32'(bif.bus_write), 32'd1);
        chk($sformatf("both_read_c%0d", c), 32'(bif.bus_read), 32'd0);
      end
      step();
      if (c == AC + 1) begin
        bif.cpu_read  = 1'b0;
        bif.cpu_write = 1'b0;
      end
    end

    // Reset during a DMA write abandons it.
    bif.dma_req   = 1'b1;
    bif.dma_we    = 1'b1;
    bif.dma_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("rd_grant_c1", 32'(bif.dma_grant), 32'd0);
    step();
    @(negedge clk);
    chk("rd_grant_c2", 32'(bif.dma_grant), 32'd1);
    chk("rd_write_c2", 32'(bif.bus_write), 32'd1);
    #2;
    reset       = 1'b0;
    bif.dma_req = 1'b0;
    #1;
    chk("rd_write_rst", 32'(bif.bus_write), 32'd0);
    chk("rd_ack_rst", 32'(bif.dma_ack), 32'd0);
    chk("rd_grant_rst", 32'(bif.dma_grant), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bif.dma_ack || bif.dma_grant) seen = 1'b1;
    end
    chk("rd_no_ack_after", 32'(seen), 32'd0);
    step();

    // Continuous CPU and DMA demand: grant order.
    bif.cpu_read = 1'b1;
    bif.cpu_addr = 32'h4000_0004;
    bif.dma_req  = 1'b1;
    bif.dma_we   = 1'b0;
    prev_busy    = 1'b0;
    for (int k = 0; k < 10 * (AC + 1) + 20 && seq.size() < 10; k++) begin
      @(negedge clk);
      busy = bif.dma_grant | bif.bus_read | bif.bus_write;
      if (busy && !prev_busy) seq.push_back(bif.dma_grant);
      prev_busy = busy;
    end
    chk("stv_count", 32'(seq.size()), 32'd10);
    for (int i = 0; i < seq.size(); i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_d = ((i + 1) % (SL + 1)) == 0;
`else
      exp_d = 1'b0;
`endif
      chk($sformatf("stv_grant%0d", i), 32'(seq[i]), 32'(exp_d));
    end
    step();
    bif.cpu_read = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < AC + 3; k++) begin
      @(negedge clk);
      if (bif.dma_grant) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stv_dma_after_cpu", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < AC + 3; k++) begin
      if (bif.dma_ack) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) fail("stv_dma_ack");
    step();
    bif.dma_req = 1'b0;
    step();
    step();

    // Random traffic: CPU owns words 0..7, DMA owns words 8..15.
    use_fixed = 1'b0;
    mem_init  = 1'b1;
    step();
    mem_init = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    sb_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          int op;
          op = $urandom_range(0, 3);
          cpu_op(op < 2 ? 1'b1 : (op == 3), op >= 2,
                 $urandom_range(0, 7), $urandom);
          repeat ($urandom_range(0, 3)) step();
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          dma_op(1'($urandom_range(0, 1)), $urandom_range(8, 15), $urandom);
          repeat ($urandom_range(0, 4)) step();
        end
      end
    join
    repeat (3) step();
    sb_on = 1'b0;
    chk("cpu_q_left", 32'(cpu_q.size()), 32'd0);
    chk("dma_q_left", 32'(dma_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
